// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: one full-subtractor cell and a borrow flop, LSB first.
// Operands enter through a valid/ready handshake; the result leaves through another.
module serial_subtractor #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         bout
);
    localparam int CW = $clog2(W) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    logic [1:0]    r_state;
    logic [W-1:0]  r_aSh;
    logic [W-1:0]  r_bSh;
    logic [W-1:0]  r_diff;
    logic          r_borrow;
    logic          r_bout;
    logic [CW-1:0] r_count;

    logic          w_a0;
    logic          w_b0;
    logic          w_d;
    logic          w_borrowNext;
    logic [W-1:0]  w_diffNext;

    assign w_a0         = r_aSh[0];
    assign w_b0         = r_bSh[0];
    assign w_d          = w_a0 ^ w_b0 ^ r_borrow;
    assign w_borrowNext = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_borrow);

    // Each difference bit enters at the MSB so the LSB lands at bit 0 after W shifts.
    generate
        if (W == 1) begin : g_narrow
            assign w_diffNext = w_d;
        end else begin : g_wide
            assign w_diffNext = {w_d, r_diff[W-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_aSh    <= '0;
            r_bSh    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_aSh    <= a;
                        r_bSh    <= b;
                        r_borrow <= bin;
                        r_count  <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_diff   <= w_diffNext;
                    r_borrow <= w_borrowNext;
                    r_aSh    <= r_aSh >> 1;
                    r_bSh    <= r_bSh >> 1;
                    r_count  <= r_count + 1'b1;
                    if (r_count == LAST_BIT) begin
                        r_bout  <= w_borrowNext;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign diff      = r_diff;
    assign bout      = r_bout;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: an 8-bit and a 1-bit instance share clock and reset,
// and every accepted operand set pushes its expected {bout,diff} onto a scoreboard queue.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    logic       inValid8, inReady8, bin8, outValid8, outReady8, bout8;
    logic [7:0] a8, b8, diff8;

    logic       inValid1, inReady1, bin1, outValid1, outReady1, bout1;
    logic [0:0] a1, b1, diff1;

    int passCount  = 0;
    int checkCount = 0;

    logic [8:0] sbq8[$];
    logic [1:0] sbq1[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] expDiff;
        logic       expBout;
    } vec8_t;

    typedef struct {
        logic a;
        logic b;
        logic bin;
        logic expD;
        logic expBout;
    } vec1_t;

    vec8_t vecs8[8];
    vec1_t vecs1[8];

    serial_subtractor #(.W(8)) dut8 (
        .clk(clk), .rstn(rstn),
        .in_valid(inValid8), .in_ready(inReady8),
        .a(a8), .b(b8), .bin(bin8),
        .out_valid(outValid8), .out_ready(outReady8),
        .diff(diff8), .bout(bout8)
    );

    serial_subtractor #(.W(1)) dut1 (
        .clk(clk), .rstn(rstn),
        .in_valid(inValid1), .in_ready(inReady1),
        .a(a1), .b(b1), .bin(bin1),
        .out_valid(outValid1), .out_ready(outReady1),
        .diff(diff1), .bout(bout1)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitReady8();
        int guard = 0;
        while (!inReady8 && guard < 100) begin
            tick();
            guard++;
        end
        if (!inReady8) checkOutput("inReadyTimeout8", 32'(inReady8), 32'd1);
    endtask

    task automatic waitValid8(output int latency);
        latency = 0;
        while (!outValid8 && latency < 100) begin
            tick();
            latency++;
        end
    endtask

    task automatic popCompare8(input string name);
        logic [8:0] exp;
        if (sbq8.size() == 0) begin
            checkOutput({name, "_sbEmpty"}, 32'(sbq8.size()), 32'd1);
        end else begin
            exp = sbq8.pop_front();
            checkOutput(name, 32'({bout8, diff8}), 32'(exp));
        end
    endtask

    // Full transaction on the 8-bit instance; operand pins are scrambled right after the accept edge.
    task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                                  input logic [8:0] exp, output int latency);
        waitReady8();
        a8 = a; b8 = b; bin8 = bin; inValid8 = 1'b1;
        sbq8.push_back(exp);
        tick();
        inValid8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        waitValid8(latency);
        popCompare8("result8");
        outReady8 = 1'b1;
        tick();
        outReady8 = 1'b0;
        checkOutput("outValidDrop8", 32'(outValid8), 32'd0);
        checkOutput("inReadyBack8", 32'(inReady8), 32'd1);
    endtask

    task automatic applyStimulus1(input logic a, input logic b, input logic bin, input logic [1:0] exp);
        int latency = 0;
        logic [1:0] got;
        int guard = 0;
        while (!inReady1 && guard < 100) begin
            tick();
            guard++;
        end
        a1 = a; b1 = b; bin1 = bin; inValid1 = 1'b1;
        sbq1.push_back(exp);
        tick();
        inValid1 = 1'b0;
        while (!outValid1 && latency < 100) begin
            tick();
            latency++;
        end
        checkOutput("latency1", 32'(latency), 32'd1);
        got = {bout1, diff1};
        if (sbq1.size() == 0) checkOutput("sbEmpty1", 32'(sbq1.size()), 32'd1);
        else checkOutput("result1", 32'(got), 32'(sbq1.pop_front()));
        outReady1 = 1'b1;
        tick();
        outReady1 = 1'b0;
        checkOutput("outValidDrop1", 32'(outValid1), 32'd0);
    endtask

    initial begin : main
        int lat;
        localparam int N_RANDOM = 1500;

        vecs8[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0};
        vecs8[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs8[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs8[3] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0};
        vecs8[4] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
        vecs8[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs8[6] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
        vecs8[7] = '{8'h01, 8'h01, 1'b1, 8'hFF, 1'b1};

        vecs1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        rstn = 1'b0;
        inValid8 = 1'b0; outReady8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        inValid1 = 1'b0; outReady1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        #12;
        checkOutput("rstInReady", 32'(inReady8), 32'd1);
        checkOutput("rstOutValid", 32'(outValid8), 32'd0);
        checkOutput("rstDiffBout", 32'({bout8, diff8}), 32'd0);
        @(negedge clk) rstn = 1'b1;
        tick();

        $display("[TB] basic subtraction and latency");
        applyStimulus8(8'h5A, 8'h23, 1'b0, 9'h037, lat);
        checkOutput("latency8", 32'(lat), 32'd8);

        $display("[TB] vector table, W=8");
        for (int i = 0; i < 8; i++) begin
            applyStimulus8(vecs8[i].a, vecs8[i].b, vecs8[i].bin, {vecs8[i].expBout, vecs8[i].expDiff}, lat);
            checkOutput("latencyTable8", 32'(lat), 32'd8);
        end

        // Result must hold through 5 stalled cycles while a competing operand set is offered.
        $display("[TB] backpressure in DONE");
        waitReady8();
        a8 = 8'hC3; b8 = 8'h3C; bin8 = 1'b0; inValid8 = 1'b1;
        sbq8.push_back(9'h087);
        tick();
        inValid8 = 1'b0;
        waitValid8(lat);
        a8 = 8'h01; b8 = 8'h02; bin8 = 1'b1; inValid8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("stallOutValid", 32'(outValid8), 32'd1);
            checkOutput("stallResult", 32'({bout8, diff8}), 32'h087);
            checkOutput("stallInReady", 32'(inReady8), 32'd0);
        end
        inValid8 = 1'b0;
        popCompare8("stallPop");
        outReady8 = 1'b1;
        tick();
        outReady8 = 1'b0;
        checkOutput("stallRelease", 32'({inReady8, outValid8}), 32'b10);
        tick();
        checkOutput("noHiddenAccept", 32'({inReady8, outValid8}), 32'b10);

        $display("[TB] reset during RUN");
        waitReady8();
        a8 = 8'h77; b8 = 8'h11; bin8 = 1'b0; inValid8 = 1'b1;
        tick();
        inValid8 = 1'b0;
        tick();
        tick();
        #2 rstn = 1'b0;
        #1;
        checkOutput("abortOutValid", 32'(outValid8), 32'd0);
        checkOutput("abortInReady", 32'(inReady8), 32'd1);
        checkOutput("abortDiff", 32'({bout8, diff8}), 32'd0);
        @(negedge clk) rstn = 1'b1;
        tick();
        applyStimulus8(8'h10, 8'h01, 1'b0, 9'h00F, lat);
        checkOutput("postResetLatency", 32'(lat), 32'd8);

        $display("[TB] full subtractor truth table, W=1");
        for (int i = 0; i < 8; i++) begin
            applyStimulus1(vecs1[i].a, vecs1[i].b, vecs1[i].bin, {vecs1[i].expBout, vecs1[i].expD});
        end

        // Driver and consumer run independently with random gaps; the queue pairs them in order.
        $display("[TB] random back-to-back traffic");
        fork
            begin : driver
                logic [7:0] ra, rb;
                logic       rbin;
                for (int i = 0; i < N_RANDOM; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    waitReady8();
                    ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom_range(0, 1));
                    a8 = ra; b8 = rb; bin8 = rbin; inValid8 = 1'b1;
                    sbq8.push_back({1'b0, ra} - {1'b0, rb} - {8'd0, rbin});
                    tick();
                    inValid8 = 1'b0;
                end
            end
            begin : consumer
                int got = 0;
                int guard = 0;
                while (got < N_RANDOM && guard < N_RANDOM * 40) begin
                    @(negedge clk);
                    outReady8 = ($urandom_range(0, 3) != 0);
                    if (outValid8 && outReady8) begin
                        popCompare8("random");
                        got++;
                    end
                    guard++;
                end
                checkOutput("randomCount", 32'(got), 32'(N_RANDOM));
                @(negedge clk) outReady8 = 1'b0;
            end
        join
        checkOutput("sbDrained", 32'(sbq8.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
